img_pkt_framer: RTL

IMG_PKT_FRAMER -- requirements
Module: img_pkt_framer

---
 rtl/img_pkt_framer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/img_pkt_framer.sv
// img_pkt_framer: buffers camera pixels in a payload FIFO and serves them to a UDP
// core as packets of LINES_PER_PKT lines, one byte per udp_tx_req.
//
// Build option: define IMG_PKT_HEADER_EN to prepend a 12-byte header
// (frame marker, frame count, line count, line width, lines per packet).
//
// Ports:
//   eth_tx_clk      in   single clock, rising edge
//   rst             in   asynchronous active-high reset
//   img_vsync       in   frame sync, falling edge starts a frame
//   img_data_en     in   pixel valid
//   img_data        in   pixel, DATA_W bits
//   transfer_flag   in   1 = transmission enabled
//   udp_tx_req      in   byte read request from the UDP core
//   udp_tx_done     in   one-cycle pulse: packet sent
//   udp_tx_start_en out  one-cycle packet start pulse
//   udp_tx_data     out  packet byte, valid the cycle after a req
//   udp_tx_byte_num out  packet length in bytes
//   frame_cnt       out  frame number
//   fifo_ovf        out  sticky overflow/drop flag
module img_pkt_framer #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned H_PIXEL       = 640,
    parameter int unsigned V_PIXEL       = 480,
    parameter int unsigned LINES_PER_PKT = 1,
    parameter int unsigned FIFO_AW       = 11,
    parameter logic [31:0] FRAME_HEAD    = 32'hF05AA50F
) (
    input  logic              eth_tx_clk,
    input  logic              rst,
    input  logic              img_vsync,
    input  logic              img_data_en,
    input  logic [DATA_W-1:0] img_data,
    input  logic              transfer_flag,
    input  logic              udp_tx_req,
    input  logic              udp_tx_done,
    output logic              udp_tx_start_en,
    output logic [7:0]        udp_tx_data,
    output logic [15:0]       udp_tx_byte_num,
    output logic [15:0]       frame_cnt,
    output logic              fifo_ovf
);

    localparam int unsigned PKT_PIX   = H_PIXEL * LINES_PER_PKT;
    localparam int unsigned PAY_BYTES = PKT_PIX * (DATA_W / 8);
`ifdef IMG_PKT_HEADER_EN
    localparam int unsigned HDR_BYTES = 12;
    localparam logic [15:0] HPIX16    = 16'(H_PIXEL);
    localparam logic [15:0] LPP16     = 16'(LINES_PER_PKT);
`else
    localparam int unsigned HDR_BYTES = 0;
`endif
    localparam logic [15:0]      BYTE_NUM = 16'(HDR_BYTES + PAY_BYTES);
    localparam logic [15:0]      PAY_LAST = 16'(PAY_BYTES - 1);
    localparam logic [FIFO_AW:0] PKT_LVL  = (FIFO_AW + 1)'(PKT_PIX);
    localparam logic [16:0]      V_LINES  = 17'(V_PIXEL);
    localparam logic [16:0]      LPP17    = 17'(LINES_PER_PKT);

    typedef enum logic [2:0] {
        StIdle, StWaitData, StStart, StHead, StPayload, StWaitDone
    } state_t;

    state_t state_q, state_d;

    logic              vs_q1, vs_q2;
    logic [DATA_W-1:0] mem [2**FIFO_AW];
    logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q, level;
    logic [15:0]       rd16;
    logic [15:0]       byte_idx_q, line_cnt_q;
    logic [16:0]       line_sum;
    logic [7:0]        lo_byte_q, hdr_byte;
    logic              lo_phase_q, flush_pend_q;
    logic              frame_start, pkt_busy, defer, pkt_done, new_frame;
    logic              full, wr_try, fifo_wr, drop, pay_req, pop;

    assign frame_start = vs_q2 & ~vs_q1;
    assign pkt_busy    = (state_q == StHead) || (state_q == StPayload) ||
                         (state_q == StWaitDone);
    // A frame start mid-packet is deferred to udp_tx_done; START only defers if it will proceed.
    assign defer       = frame_start && (pkt_busy || (state_q == StStart && transfer_flag));
    assign pkt_done    = udp_tx_done && pkt_busy;
    assign new_frame   = (frame_start && !defer) || (pkt_done && (flush_pend_q || frame_start));

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = level[FIFO_AW];
    assign wr_try  = img_data_en && transfer_flag;
    assign fifo_wr = wr_try && !full && !flush_pend_q && !new_frame;
    assign drop    = wr_try && (full || flush_pend_q);
    assign rd16    = 16'(mem[rd_ptr_q[FIFO_AW-1:0]]);
    assign pay_req = udp_tx_req && (state_q == StPayload);
    // 16-bit pixels pop on the high byte; the low byte is served from lo_byte_q.
    assign pop     = pay_req && ((DATA_W == 8) || !lo_phase_q);
    assign line_sum = 17'(line_cnt_q) + LPP17;

`ifdef IMG_PKT_HEADER_EN
    always_comb begin
        hdr_byte = 8'h00;
        case (byte_idx_q[3:0])
            4'd0:    hdr_byte = FRAME_HEAD[31:24];
            4'd1:    hdr_byte = FRAME_HEAD[23:16];
            4'd2:    hdr_byte = FRAME_HEAD[15:8];
            4'd3:    hdr_byte = FRAME_HEAD[7:0];
            4'd4:    hdr_byte = frame_cnt[15:8];
            4'd5:    hdr_byte = frame_cnt[7:0];
            4'd6:    hdr_byte = line_cnt_q[15:8];
            4'd7:    hdr_byte = line_cnt_q[7:0];
            4'd8:    hdr_byte = HPIX16[15:8];
            4'd9:    hdr_byte = HPIX16[7:0];
            4'd10:   hdr_byte = LPP16[15:8];
            4'd11:   hdr_byte = LPP16[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end
`else
    assign hdr_byte = 8'h00;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (new_frame && transfer_flag) state_d = StWaitData;
            end
            StWaitData: begin
                if (!transfer_flag) state_d = StIdle;
                else if (!new_frame && level >= PKT_LVL) state_d = StStart;
            end
            StStart: begin
                if (!transfer_flag) state_d = StIdle;
`ifdef IMG_PKT_HEADER_EN
                else state_d = StHead;
`else
                else state_d = StPayload;
`endif
            end
            StHead: begin
                if (udp_tx_req && byte_idx_q == 16'd11) state_d = StPayload;
            end
            StPayload: begin
                if (udp_tx_req && byte_idx_q == PAY_LAST) state_d = StWaitDone;
            end
            default: state_d = state_q;
        endcase
        if (pkt_done) begin
            if (!transfer_flag) state_d = StIdle;
            else if (new_frame) state_d = StWaitData;
            else if (line_sum >= V_LINES) state_d = StIdle;
            else state_d = StWaitData;
        end
    end

    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            vs_q1           <= 1'b0;
            vs_q2           <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            byte_idx_q      <= '0;
            line_cnt_q      <= '0;
            lo_byte_q       <= '0;
            lo_phase_q      <= 1'b0;
            flush_pend_q    <= 1'b0;
            udp_tx_start_en <= 1'b0;
            udp_tx_data     <= '0;
            udp_tx_byte_num <= '0;
            frame_cnt       <= '0;
            fifo_ovf        <= 1'b0;
        end else begin
            vs_q1           <= img_vsync;
            vs_q2           <= vs_q1;
            state_q         <= state_d;
            udp_tx_start_en <= (state_q == StStart) && transfer_flag;
            if (state_q == StStart && transfer_flag) begin
                udp_tx_byte_num <= BYTE_NUM;
                byte_idx_q      <= '0;
                lo_phase_q      <= 1'b0;
            end
            if (new_frame) begin
                frame_cnt  <= frame_cnt + 16'd1;
                line_cnt_q <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
            end else begin
                if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (pkt_done) line_cnt_q <= line_sum[15:0];
            end
            if (new_frame) flush_pend_q <= 1'b0;
            else if (defer) flush_pend_q <= 1'b1;
            if (drop) fifo_ovf <= 1'b1;
            if (udp_tx_req && state_q == StHead) begin
                udp_tx_data <= hdr_byte;
                byte_idx_q  <= (byte_idx_q == 16'd11) ? 16'd0 : byte_idx_q + 16'd1;
            end
            if (pay_req) begin
                byte_idx_q <= byte_idx_q + 16'd1;
                if (DATA_W == 8) begin
                    udp_tx_data <= rd16[7:0];
                end else if (!lo_phase_q) begin
                    udp_tx_data <= rd16[15:8];
                    lo_byte_q   <= rd16[7:0];
                    lo_phase_q  <= 1'b1;
                end else begin
                    udp_tx_data <= lo_byte_q;
                    lo_phase_q  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge eth_tx_clk) begin
        if (fifo_wr) mem[wr_ptr_q[FIFO_AW-1:0]] <= img_data;
    end

endmodule
